nr_seq_divider: RTL and testbench
=================================

Name: nr_seq_divider

Overview:
Parameterised iterative non-restoring divider. It supersedes the fixed 32-bit free-running divider with a start/done handshake, a runtime signed/unsigned mode, correct signed remainders and divide-by-zero detection. It sits beside the ALU and feeds the datapath Z register, with quotient to Z low and remainder to Z high. The control unit holds the DIV instruction until done is asserted.

Parameters:
WIDTH, 32, operand, quotient and remainder width; must be at least 4.
SIGNED_EN, 1, when 0 the is_signed input is ignored and all operations are unsigned.

Ports:
clk  in  1  rising-edge clock
resetn  in  1  synchronous active-low reset
start  in  1  request a division; sampled only when busy=0
is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
dividend  in  WIDTH  numerator; sampled with start
divisor  in  WIDTH  denominator; sampled with start
busy  out  1  high while an operation is in flight
done  out  1  one-cycle pulse when quotient, remainder and div_by_zero are valid
div_by_zero  out  1  set with done if divisor was 0; held until the next accepted start
quotient  out  WIDTH  registered result; held until the next done
remainder  out  WIDTH  registered result; held until the next done

Behaviour:
- Reset:
  - Clock is clk; reset is resetn, synchronous, active-low.
  - On reset: state=IDLE, busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, iteration counter=0.
  - Reset mid-operation aborts the division immediately; no done is produced.
- States:
  - IDLE: busy=0. A start at edge k latches the operands.
    - If divisor==0, stay in IDLE and, at edge k, set quotient=all-ones, remainder=dividend, div_by_zero=1, done=1.
    - Otherwise go to CALC with busy=1 and div_by_zero cleared.
    - On start, latch magnitudes |dividend| and |divisor| (two's-complement negation when signed and MSB=1; unchanged when unsigned).
    - Latch sign flags: q_neg = signed and (sign(dividend) XOR sign(divisor)); r_neg = signed and sign(dividend).
  - CALC: exactly WIDTH iterations, one per clock, over a 2*WIDTH+1-bit A:Q register.
    - Each iteration: shift A:Q left by 1.
    - If A was non-negative before the shift, A = A - M; else A = A + M.
    - Q[0] = NOT A[msb].
    - After iteration WIDTH, go to FIX.
  - FIX: one cycle.
    - If A is negative, A = A + M.
    - quotient = q_neg ? -Q : Q; remainder = r_neg ? -A : A; both truncated to WIDTH.
    - done=1, busy=0, state goes to IDLE.
- Latency: start at edge k gives done high in the cycle after edge k+WIDTH+1 (WIDTH+2 edges in total).
- done is high for exactly one cycle.
- Back-to-back: start may be asserted in the same cycle done is high; it is accepted, and outputs hold the previous result until the new done.
- Throughput: one operation per WIDTH+2 cycles.
- start while busy=1 is ignored. Operand inputs may change freely after acceptance.
- Signed semantics: truncation toward zero. The remainder takes the sign of the dividend; a zero remainder is never negative. This satisfies dividend = quotient*divisor + remainder.
- Signed overflow: MIN / -1 gives quotient=MIN (0x80000000 for WIDTH=32) and remainder=0 through natural wrap. No flag is raised.
- Divide by zero uses the same result in signed and unsigned mode.

Test Plan:
1. Unsigned 38 / 6, start at edge 0 -> busy for 33 cycles, done at cycle 34, quotient=6, remainder=2, div_by_zero=0.
2. Signed (WIDTH=32) -38/6 -> q=0xFFFFFFFA, r=0xFFFFFFFE; 38/-6 -> q=0xFFFFFFFA, r=2; -38/-6 -> q=6, r=0xFFFFFFFE.
3. Mode check: operands 0xFFFFFFFF / 2:
   - Unsigned -> q=0x7FFFFFFF, r=1.
   - Signed -> q=0, r=0xFFFFFFFF.
   - Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
4. Divide by zero: 100 / 0 -> done one cycle after start, q=0xFFFFFFFF, r=100, div_by_zero=1. The next valid start clears div_by_zero.
5. Protocol:
   - Second start with different operands during CALC is ignored; the result matches the first operands.
   - start held high through done starts the next operation back-to-back, with the second done WIDTH+2 cycles later.
6. resetn=0 at cycle 10 of CALC -> busy=0, quotient=remainder=0, no done pulse. A new start after reset completes normally (e.g. 100/25 -> q=4, r=0). Repeat scenario 1 with WIDTH=8 (38/6, done after 10 edges).

Source files
------------

// File: rtl/nr_seq_divider.sv
// Iterative non-restoring divider with a start/done handshake, runtime
// signed/unsigned mode and divide-by-zero detection. One quotient bit is
// produced per clock over a WIDTH+1-bit partial remainder (A) and a WIDTH-bit
// quotient shift register (Q).
module nr_seq_divider #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state,       state_nx;
    logic [WIDTH:0]   acc,         acc_nx;
    logic [WIDTH-1:0] quo,         quo_nx;
    logic [WIDTH:0]   mag,         mag_nx;
    logic [CW-1:0]    cnt,         cnt_nx;
    logic             q_neg,       q_neg_nx;
    logic             r_neg,       r_neg_nx;
    logic             done_nx;
    logic             dbz_nx;
    logic [WIDTH-1:0] quotient_nx, remainder_nx;

    logic             op_signed;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   acc_sh, acc_step, acc_fix;

    // Operand magnitudes and the per-iteration add/subtract datapath.
    assign op_signed = SIGNED_EN && is_signed;
    assign dvd_mag   = (op_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_mag   = (op_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign acc_sh    = {acc[WIDTH-1:0], quo[WIDTH-1]};
    assign acc_step  = acc[WIDTH] ? (acc_sh + mag) : (acc_sh - mag);
    assign acc_fix   = acc[WIDTH] ? (acc + mag) : acc;
    assign busy      = (state != IDLE);

    // Next-state and next-datapath logic for the IDLE/CALC/FIX sequence.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_nx     = state;
        acc_nx       = acc;
        quo_nx       = quo;
        mag_nx       = mag;
        cnt_nx       = cnt;
        q_neg_nx     = q_neg;
        r_neg_nx     = r_neg;
        done_nx      = 1'b0;
        dbz_nx       = div_by_zero;
        quotient_nx  = quotient;
        remainder_nx = remainder;

        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_nx  = '1;
                        remainder_nx = dividend;
                        dbz_nx       = 1'b1;
                        done_nx      = 1'b1;
                    end else begin
                        state_nx = CALC;
                        dbz_nx   = 1'b0;
                        acc_nx   = '0;
                        quo_nx   = dvd_mag;
                        mag_nx   = {1'b0, dvs_mag};
                        cnt_nx   = '0;
                        q_neg_nx = op_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_nx = op_signed && dividend[WIDTH-1];
                    end
                end
            end
            CALC: begin
                acc_nx = acc_step;
                quo_nx = {quo[WIDTH-2:0], ~acc_step[WIDTH]};
                if (cnt == CW'(WIDTH - 1)) begin
                    cnt_nx   = '0;
                    state_nx = FIX;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            FIX: begin
                acc_nx       = acc_fix;
                quotient_nx  = q_neg ? -quo : quo;
                remainder_nx = r_neg ? -acc_fix[WIDTH-1:0] : acc_fix[WIDTH-1:0];
                done_nx      = 1'b1;
                state_nx     = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, datapath and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!resetn) begin
            // NOTE: every register here is a flop, so all of them are reset;
            // a reset mid-division simply discards the partial result.
            state       <= IDLE;
            acc         <= '0;
            quo         <= '0;
            mag         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            state       <= state_nx;
            acc         <= acc_nx;
            quo         <= quo_nx;
            mag         <= mag_nx;
            cnt         <= cnt_nx;
            q_neg       <= q_neg_nx;
            r_neg       <= r_neg_nx;
            done        <= done_nx;
            div_by_zero <= dbz_nx;
            quotient    <= quotient_nx;
            remainder   <= remainder_nx;
        end
    end

endmodule

// File: tb/tb_nr_seq_divider.sv
// Self-checking bench for nr_seq_divider: a 32-bit and an 8-bit instance are
// compared every cycle against a transaction-level model built on plain
// integer division, plus literal expectations for hand-computed cases.
module tb_nr_seq_divider;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    bit   chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Index 0 drives the WIDTH=32 instance, index 1 the WIDTH=8 instance.
    logic        start_a [2];
    logic        sgn_a   [2];
    logic [31:0] dvd_a   [2];
    logic [31:0] dvs_a   [2];
    logic        busy_a  [2];
    logic        done_a  [2];
    logic        dbz_a   [2];
    logic [31:0] q_a     [2];
    logic [31:0] r_a     [2];

    logic [31:0] q32, r32;
    logic [7:0]  q8, r8;

    always #5 clk = ~clk;

    nr_seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) u_div32 (
        .clk(clk), .resetn(resetn), .start(start_a[0]), .is_signed(sgn_a[0]),
        .dividend(dvd_a[0]), .divisor(dvs_a[0]), .busy(busy_a[0]), .done(done_a[0]),
        .div_by_zero(dbz_a[0]), .quotient(q32), .remainder(r32)
    );

    nr_seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) u_div8 (
        .clk(clk), .resetn(resetn), .start(start_a[1]), .is_signed(sgn_a[1]),
        .dividend(dvd_a[1][7:0]), .divisor(dvs_a[1][7:0]), .busy(busy_a[1]), .done(done_a[1]),
        .div_by_zero(dbz_a[1]), .quotient(q8), .remainder(r8)
    );

    assign q_a[0] = q32;
    assign r_a[0] = r32;
    assign q_a[1] = {24'b0, q8};
    assign r_a[1] = {24'b0, r8};

    function automatic int width_of(int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic logic [31:0] mask_of(int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Reference result from the arithmetic definition (truncating division).
    function automatic void ref_div(input int w, input bit sgn, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] q,
                                    output logic [31:0] r);
        longint sa, sb, sq, sr;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        sq = sa / sb;
        sr = sa % sb;
        q = sq[31:0] & mask_of(w);
        r = sr[31:0] & mask_of(w);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Transaction model: accept, count WIDTH+1 edges, then publish the result.
    logic        m_done [2];
    logic        m_dbz  [2];
    logic [31:0] m_q    [2];
    logic [31:0] m_r    [2];
    logic [31:0] m_pq   [2];
    logic [31:0] m_pr   [2];
    int          m_rem  [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [31:0] a, b, tq, tr;
            int w;
            w = width_of(i);
            if (!resetn) begin
                m_done[i] = 1'b0;
                m_dbz[i]  = 1'b0;
                m_q[i]    = '0;
                m_r[i]    = '0;
                m_rem[i]  = 0;
            end else begin
                m_done[i] = 1'b0;
                if (m_rem[i] > 0) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_done[i] = 1'b1;
                        m_q[i]    = m_pq[i];
                        m_r[i]    = m_pr[i];
                    end
                end else if (start_a[i]) begin
                    a = dvd_a[i] & mask_of(w);
                    b = dvs_a[i] & mask_of(w);
                    if (b == 0) begin
                        m_done[i] = 1'b1;
                        m_dbz[i]  = 1'b1;
                        m_q[i]    = mask_of(w);
                        m_r[i]    = a;
                    end else begin
                        m_dbz[i] = 1'b0;
                        m_rem[i] = w + 1;
                        ref_div(w, sgn_a[i], a, b, tq, tr);
                        m_pq[i] = tq;
                        m_pr[i] = tr;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("i%0d_busy", i), 32'(busy_a[i]), 32'(m_rem[i] > 0));
                check($sformatf("i%0d_done", i), 32'(done_a[i]), 32'(m_done[i]));
                check($sformatf("i%0d_dbz", i),  32'(dbz_a[i]),  32'(m_dbz[i]));
                check($sformatf("i%0d_quot", i), q_a[i], m_q[i]);
                check($sformatf("i%0d_rem", i),  r_a[i], m_r[i]);
            end
        end
    end

    task automatic do_start(input int i, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_a[i] = 1'b1;
        sgn_a[i]   = sgn;
        dvd_a[i]   = a;
        dvs_a[i]   = b;
        @(negedge clk);
        start_a[i] = 1'b0;
        dvd_a[i]   = $urandom;
        dvs_a[i]   = $urandom;
    endtask

    task automatic wait_done(input int i, input int budget, output int cyc);
        cyc = 0;
        while (done_a[i] !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (done_a[i] !== 1'b1)
            check($sformatf("i%0d_done_timeout", i), 32'(done_a[i]), 32'd1);
    endtask

    task automatic op(input int i, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eq, input logic [31:0] er, input string tag);
        int cyc;
        do_start(i, sgn, a, b);
        wait_done(i, 100, cyc);
        check({tag, "_q"}, q_a[i], eq);
        check({tag, "_r"}, r_a[i], er);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 2; i++) begin
            start_a[i] = 1'b0;
            sgn_a[i]   = 1'b0;
            dvd_a[i]   = '0;
            dvs_a[i]   = '0;
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        chk_en = 1'b1;
        check("rst_busy", 32'(busy_a[0]), 32'd0);
        check("rst_done", 32'(done_a[0]), 32'd0);
        check("rst_q",    q_a[0], 32'd0);
        check("rst_r",    r_a[0], 32'd0);

        // Unsigned 38/6 with latency.
        do_start(0, 1'b0, 32'd38, 32'd6);
        wait_done(0, 100, cyc);
        check("t1_latency", 32'(cyc), 32'd33);
        check("t1_q", q_a[0], 32'd6);
        check("t1_r", r_a[0], 32'd2);
        check("t1_dbz", 32'(dbz_a[0]), 32'd0);

        // Signed sign combinations.
        op(0, 1'b1, 32'hFFFF_FFDA, 32'd6,          32'hFFFF_FFFA, 32'hFFFF_FFFE, "t2_nd");
        op(0, 1'b1, 32'd38,        32'hFFFF_FFFA,  32'hFFFF_FFFA, 32'd2,         "t2_nv");
        op(0, 1'b1, 32'hFFFF_FFDA, 32'hFFFF_FFFA,  32'd6,         32'hFFFF_FFFE, "t2_nn");

        // Mode and overflow.
        op(0, 1'b0, 32'hFFFF_FFFF, 32'd2,          32'h7FFF_FFFF, 32'd1,         "t3_u");
        op(0, 1'b1, 32'hFFFF_FFFF, 32'd2,          32'd0,         32'hFFFF_FFFF, "t3_s");
        op(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         "t3_ovf");

        // Divide by zero, then a valid start clears the flag.
        do_start(0, 1'b0, 32'd100, 32'd0);
        wait_done(0, 100, cyc);
        check("t4_latency", 32'(cyc), 32'd0);
        check("t4_q", q_a[0], 32'hFFFF_FFFF);
        check("t4_r", r_a[0], 32'd100);
        check("t4_dbz", 32'(dbz_a[0]), 32'd1);
        op(0, 1'b1, 32'd7, 32'd2, 32'd3, 32'd1, "t4_after");
        check("t4_dbz_clr", 32'(dbz_a[0]), 32'd0);

        // Start during CALC is ignored.
        do_start(0, 1'b0, 32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        do_start(0, 1'b0, 32'd50, 32'd5);
        wait_done(0, 100, cyc);
        check("t5_ign_q", q_a[0], 32'd142);
        check("t5_ign_r", r_a[0], 32'd6);

        // Start held through done: back-to-back operation.
        @(negedge clk);
        start_a[0] = 1'b1;
        sgn_a[0]   = 1'b0;
        dvd_a[0]   = 32'd38;
        dvs_a[0]   = 32'd6;
        wait_done(0, 100, cyc);
        check("t5_b2b1_q", q_a[0], 32'd6);
        check("t5_b2b1_r", r_a[0], 32'd2);
        dvd_a[0] = 32'd100;
        dvs_a[0] = 32'd7;
        @(negedge clk);
        start_a[0] = 1'b0;
        check("t5_b2b_hold_q", q_a[0], 32'd6);
        wait_done(0, 100, cyc);
        check("t5_b2b2_gap", 32'(cyc + 1), 32'd34);
        check("t5_b2b2_q", q_a[0], 32'd14);
        check("t5_b2b2_r", r_a[0], 32'd2);

        // Reset in the middle of CALC aborts without done.
        do_start(0, 1'b0, 32'd38, 32'd6);
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("t6_busy", 32'(busy_a[0]), 32'd0);
        check("t6_q", q_a[0], 32'd0);
        check("t6_r", r_a[0], 32'd0);
        repeat (40) @(negedge clk);
        op(0, 1'b0, 32'd100, 32'd25, 32'd4, 32'd0, "t6_after");

        // 8-bit instance.
        do_start(1, 1'b0, 32'd38, 32'd6);
        wait_done(1, 100, cyc);
        check("w8_latency", 32'(cyc), 32'd9);
        check("w8_q", q_a[1], 32'd6);
        check("w8_r", r_a[1], 32'd2);
        op(1, 1'b1, 32'hDA, 32'd6,  32'hFA, 32'hFE, "w8_neg");
        op(1, 1'b1, 32'h80, 32'hFF, 32'h80, 32'h00, "w8_ovf");
        op(1, 1'b0, 32'd100, 32'd0, 32'hFF, 32'd100, "w8_dbz");

        // Randomized operations on both widths.
        for (int n = 0; n < 60; n++) begin
            int i, w, sel;
            logic [31:0] a, b;
            i   = n % 2;
            w   = width_of(i);
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin a = 32'd1 << (w - 1); b = 32'hFFFF_FFFF; end
                3: a = $urandom_range(0, 20);
                4: b = 32'hFFFF_FFFF - $urandom_range(0, 5);
                default: ;
            endcase
            do_start(i, 1'($urandom_range(0, 1)), a, b);
            wait_done(i, 100, cyc);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
